// File: rtl/priority_encoder8x3_pkg.sv
// Shared types and helpers for the 8-to-3 priority encoder.
// Holds the FSM state enum, the width constants and the index-to-one-hot helper.
package priority_encoder8x3_pkg;

    localparam int PE_N = 8;
    localparam int PE_W = 3;

    typedef enum logic {
        PE_IDLE,
        PE_PRESENT
    } pe_state_t;

    function automatic logic [PE_N-1:0] onehot3(input logic [PE_W-1:0] idx);
        logic [PE_N-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder8x3_if.sv
// Request/handshake bundle of the priority encoder.
// master: encoder side (takes i_req/i_ready, drives o_*); slave: consumer side.
interface priority_encoder8x3_if;
    import priority_encoder8x3_pkg::*;

    logic [PE_N-1:0] i_req;
    logic            i_ready;
    logic            o_valid;
    logic [PE_W-1:0] o_code;
    logic            o_multi;
    logic [PE_N-1:0] o_pending;
    logic            o_overrun;

    modport master (
        input  i_req,
        input  i_ready,
        output o_valid,
        output o_code,
        output o_multi,
        output o_pending,
        output o_overrun
    );

    modport slave (
        output i_req,
        output i_ready,
        input  o_valid,
        input  o_code,
        input  o_multi,
        input  o_pending,
        input  o_overrun
    );

endinterface

// File: rtl/priority_encoder8x3_sel.sv
// Combinational priority selector over the pending vector.
// Ports: pend (in 8), idx (out 3), any (out 1), multi (out 1, more than one bit set).
module prio_sel8x3
    import priority_encoder8x3_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [PE_N-1:0] pend,
    output logic [PE_W-1:0] idx,
    output logic            any,
    output logic            multi
);

    always_comb begin
        idx   = '0;
        any   = |pend;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = |(pend & (pend - PE_N'(1)));
        if (LOW_FIRST) begin
            // Scan downward so the lowest set index is written last.
            for (int i = PE_N - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    idx = PE_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < PE_N; i++) begin
                if (pend[i]) begin
                    idx = PE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/priority_encoder8x3.sv
// Registered 8-to-3 priority encoder with sticky capture and valid/ready output.
// Ports: clk, rst (sync, active-high), bus (master): i_req, i_ready -> o_valid, o_code, o_multi, o_pending, o_overrun.
module priority_encoder8x3
    import priority_encoder8x3_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b0,
    parameter bit LOW_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    priority_encoder8x3_if.master bus
);

    pe_state_t       state;
    logic [PE_N-1:0] pend;
    logic [PE_N-1:0] req_q;
    logic [PE_N-1:0] set;
    logic [PE_N-1:0] clr;
    logic [PE_N-1:0] pend_n;
    logic            valid_q;
    logic [PE_W-1:0] code_q;
    logic            multi_q;
    logic            ovr_q;
    logic [PE_W-1:0] sel_idx;
    logic            sel_any;
    logic            sel_multi;

    prio_sel8x3 #(
        .LOW_FIRST(LOW_FIRST)
    ) u_sel (
        .pend (pend),
        .idx  (sel_idx),
        .any  (sel_any),
        .multi(sel_multi)
    );

    always_comb begin
        set    = EDGE_MODE ? (bus.i_req & ~req_q) : bus.i_req;
        clr    = (valid_q && bus.i_ready) ? onehot3(code_q) : '0;
        // A capture on the bit being accepted keeps it pending.
        pend_n = (pend & ~clr) | set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PE_IDLE;
            pend    <= '0;
            req_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            multi_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            req_q <= bus.i_req;
            pend  <= pend_n;
            if (|(set & pend & ~clr)) begin
                ovr_q <= 1'b1;
            end
            case (state)
                PE_IDLE: begin
                    if (sel_any) begin
                        code_q  <= sel_idx;
                        multi_q <= sel_multi;
                        valid_q <= 1'b1;
                        state   <= PE_PRESENT;
                    end
                end
                PE_PRESENT: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state   <= PE_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= PE_IDLE;
                end
            endcase
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_code    = code_q;
    assign bus.o_multi   = multi_q;
    assign bus.o_pending = pend;
    assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_priority_encoder8x3.sv
// Self-checking bench for priority_encoder8x3.
// Three instances cover level/low-first, level/high-first and edge/low-first.
module tb_priority_encoder8x3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    priority_encoder8x3_if b0 ();
    priority_encoder8x3_if b1 ();
    priority_encoder8x3_if b2 ();

    priority_encoder8x3 #(.EDGE_MODE(1'b0), .LOW_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    priority_encoder8x3 #(.EDGE_MODE(1'b0), .LOW_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    priority_encoder8x3 #(.EDGE_MODE(1'b1), .LOW_FIRST(1'b1)) u2 (
        .clk(clk), .rst(rst), .bus(b2)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ready;
        logic       valid;
        logic [2:0] code;
        logic       multi;
        logic [7:0] pend;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [7:0] q, input logic rd,
                                input logic v, input logic [2:0] c, input logic m,
                                input logic [7:0] p, input logic o);
        vec_t t;
        t.rst = r; t.req = q; t.ready = rd;
        t.valid = v; t.code = c; t.multi = m; t.pend = p; t.ovr = o;
        tbl.push_back(t);
    endfunction

    initial begin
        int k;
        int last;
        int first;
        int n6;
        logic [2:0] exp_code [3];
        logic       exp_mul  [3];

        rst        = 1'b1;
        b0.i_req   = '0; b0.i_ready = 1'b0;
        b1.i_req   = '0; b1.i_ready = 1'b0;
        b2.i_req   = '0; b2.i_ready = 1'b0;

        // reset with all requests high: nothing captured
        add(1, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        add(1, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
        add(0, 8'h01, 0, 0, 0, 0, 8'h01, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h01, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        // pattern A4 -> 2, 5, 7
        add(0, 8'hA4, 1, 0, 0, 0, 8'hA4, 0);
        add(0, 8'h00, 1, 1, 2, 1, 8'hA4, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'hA0, 0);
        add(0, 8'h00, 1, 1, 5, 1, 8'hA0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h80, 0);
        add(0, 8'h00, 1, 1, 7, 0, 8'h80, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        // backpressure on code 3, bit 1 arrives mid-stall
        add(0, 8'h08, 0, 0, 0, 0, 8'h08, 0);
        add(0, 8'h00, 0, 1, 3, 0, 8'h08, 0);
        add(0, 8'h02, 0, 1, 3, 0, 8'h0A, 0);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 0, 1, 3, 0, 8'h0A, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h02, 0);
        add(0, 8'h00, 0, 1, 1, 0, 8'h02, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        // same-cycle set and clear on bit 4
        add(0, 8'h10, 0, 0, 0, 0, 8'h10, 0);
        add(0, 8'h00, 0, 1, 4, 0, 8'h10, 0);
        add(0, 8'h10, 1, 0, 0, 0, 8'h10, 0);
        add(0, 8'h00, 0, 1, 4, 0, 8'h10, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        // reset while presenting code 5
        add(0, 8'h20, 0, 0, 0, 0, 8'h20, 0);
        add(0, 8'h00, 0, 1, 5, 0, 8'h20, 0);
        add(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        // level request held two cycles re-captures a pending bit
        add(0, 8'h01, 0, 0, 0, 0, 8'h01, 0);
        add(0, 8'h01, 0, 1, 0, 0, 8'h01, 1);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 1);

        foreach (tbl[i]) begin
            rst          = tbl[i].rst;
            b0.i_req     = tbl[i].req;
            b0.i_ready   = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d valid", i), 8'(b0.o_valid), 8'(tbl[i].valid));
            chk($sformatf("v%0d pend", i), b0.o_pending, tbl[i].pend);
            chk($sformatf("v%0d overrun", i), 8'(b0.o_overrun), 8'(tbl[i].ovr));
            if (tbl[i].valid || tbl[i].rst) begin
                chk($sformatf("v%0d code", i), 8'(b0.o_code), 8'(tbl[i].code));
                chk($sformatf("v%0d multi", i), 8'(b0.o_multi), 8'(tbl[i].multi));
            end
        end
        b0.i_req   = '0;
        b0.i_ready = 1'b0;

        // high-first order: 7, 5, 2
        exp_code[0] = 3'd7; exp_code[1] = 3'd5; exp_code[2] = 3'd2;
        exp_mul[0]  = 1'b1; exp_mul[1]  = 1'b1; exp_mul[2]  = 1'b0;
        b1.i_req   = 8'hA4;
        b1.i_ready = 1'b1;
        @(negedge clk);
        b1.i_req = '0;
        k     = 0;
        last  = 0;
        first = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (b1.o_valid) begin
                if (k == 0) first = c;
                if (k < 3) begin
                    chk($sformatf("hi code%0d", k), 8'(b1.o_code), 8'(exp_code[k]));
                    chk($sformatf("hi multi%0d", k), 8'(b1.o_multi), 8'(exp_mul[k]));
                    if (k > 0) chk($sformatf("hi gap%0d", k), 8'(c - last), 8'd2);
                end
                last = c;
                k++;
            end
        end
        chk("hi first latency", 8'(first), 8'd1);
        chk("hi code count", 8'(k), 8'd3);
        chk("hi pend end", b1.o_pending, 8'h00);
        b1.i_ready = 1'b0;

        // edge mode: held request yields one code
        b2.i_ready = 1'b1;
        b2.i_req   = 8'h40;
        n6 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b2.o_valid) begin
                n6++;
                chk("edge code", 8'(b2.o_code), 8'd6);
            end
        end
        chk("edge code count", 8'(n6), 8'd1);
        chk("edge overrun idle", 8'(b2.o_overrun), 8'd0);
        b2.i_req   = '0;
        b2.i_ready = 1'b0;
        @(negedge clk);
        b2.i_req = 8'h40;
        @(negedge clk);
        b2.i_req = '0;
        @(negedge clk);
        chk("edge2 valid", 8'(b2.o_valid), 8'd1);
        chk("edge2 overrun pre", 8'(b2.o_overrun), 8'd0);
        b2.i_req = 8'h40;
        @(negedge clk);
        chk("edge2 overrun set", 8'(b2.o_overrun), 8'd1);
        chk("edge2 pend", b2.o_pending, 8'h40);
        b2.i_req   = '0;
        b2.i_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("edge2 overrun sticky", 8'(b2.o_overrun), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("edge2 overrun rst", 8'(b2.o_overrun), 8'd0);
        chk("edge2 valid rst", 8'(b2.o_valid), 8'd0);
        chk("edge2 pend rst", b2.o_pending, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder8x3.md
# priority_encoder8x3

Registered 8-to-3 priority encoder with sticky request capture and a valid/ready output handshake. It sits at the producer end of an encode/decode pair: it collects up to eight request lines, selects the highest-priority pending request, and presents its 3-bit index to a consumer. The consumer can expand that index back to a one-hot select with a 3x8 decoder. Each request is reported exactly once per capture, and is cleared only when the consumer accepts it.

## Interface
- `EDGE_MODE`, default 0: 0 = level capture (pending bit sets every cycle its request is high); 1 = rising-edge capture (sets only on a 0→1 transition).
- `LOW_FIRST`, default 1: 1 = index 0 has highest priority; 0 = index 7 has highest priority.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  8  request lines; bit k = request k.
- `i_ready`  in  1  consumer ready.
- `o_valid`  out  1  `o_code` holds a valid index.
- `o_code`  out  3  encoded index of the selected request.
- `o_multi`  out  1  at least one other bit was still pending when `o_code` was loaded.
- `o_pending`  out  8  current pending register (debug and status).
- `o_overrun`  out  1  sticky; a capture hit a bit that was already pending. Cleared only by `rst`.

## Operation
- Pending register `pend[7:0]`:
  - Set term: `i_req` when `EDGE_MODE`=0; `i_req & ~req_q` when `EDGE_MODE`=1, where `req_q` is `i_req` registered.
  - Clear term: a one-hot of `o_code` when `o_valid & i_ready`.
  - Next value: `pend_n = (pend & ~clr) | set`. Set wins over clear on the same bit in the same cycle.
- `o_overrun` sets when `(set & pend & ~clr) != 0`.
- FSM has two states:
  - IDLE: `o_valid`=0. If `pend != 0`, load `o_code` with the priority-selected index of `pend`, load `o_multi` = (popcount(`pend`) > 1), and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: `o_valid`=1. `o_code` and `o_multi` are held stable. On `i_ready`=1, clear the bit and go to IDLE. Otherwise stay in PRESENT.
- Encoding uses only `pend` as registered, never same-cycle `i_req`.
- A request that arrives while in PRESENT never changes `o_code`. It is served in a later IDLE pass, by priority.
- `i_ready` has no effect in IDLE.

## Timing
- Reset (`rst`=1 at a clock edge): state=IDLE, `pend`=0, `req_q`=0, `o_valid`=0, `o_code`=0, `o_multi`=0, `o_overrun`=0, and therefore `o_pending`=0.
- Reset mid-operation aborts any presented code with no acceptance. `i_req` high during reset cycles is not captured.
- Latency from request to valid: `i_req[k]` high in cycle N → `pend[k]`=1 in N+1 → `o_valid`=1 with `o_code`=k in N+2, if the FSM is idle.
- Acceptance in cycle M (`o_valid` & `i_ready`): `o_valid`=0 in M+1. Next code valid in M+2 if `pend` is still nonzero. Sustained throughput is one code per 2 cycles.
- A level request held high (`EDGE_MODE`=0) re-pends in the acceptance cycle. It is therefore re-presented at M+2 and raises `o_overrun` if it was still pending when re-captured.
- All outputs are registered. There is no combinational path from `i_req` or `i_ready` to any output.

## Structure
- Package `priority_encoder8x3_pkg`:
  - State enum `pe_state_t` {`PE_IDLE`, `PE_PRESENT`}.
  - Constants `PE_N`=8 and `PE_W`=3.
  - Function `onehot3` (3-bit index → 8-bit one-hot).
- One combinational sub-module `prio_sel8x3` maps (`pend`, `LOW_FIRST`) to (`idx[2:0]`, `any`, `multi`). The top level holds the capture logic, the FSM and the output registers.

## Test plan
- Reset with `i_req`=8'hFF held for 2 cycles → all outputs 0, no capture. After `rst` falls, `o_code`=0 appears 2 cycles later (`LOW_FIRST`=1).
- `i_req`=8'b1010_0100 pulsed 1 cycle, `i_ready`=1 → codes 2, 5, 7 in that order, 2 cycles apart. `o_multi`=1, 1, 0. `o_pending` ends at 0. Repeat with `LOW_FIRST`=0 → codes 7, 5, 2.
- Backpressure: single pulse on bit 3, `i_ready`=0 for 10 cycles → `o_valid`=1 and `o_code`=3 stable throughout. A bit-1 pulse during the stall does not change `o_code`. After ready, the next code is 1.
- Same-cycle set and clear: accept code 4 while `i_req[4]` pulses → `pend[4]` stays 1, code 4 is presented again, and `o_overrun` stays 0.
- `EDGE_MODE`=1 with `i_req[6]` held high 20 cycles → exactly one code 6. A second rising edge while still pending sets `o_overrun`=1, which persists until `rst`.
- Reset asserted while in PRESENT with `o_code`=5 → the next cycle shows `o_valid`=0 and `pend`=0. The code is not re-presented.
